id_stage_controller: RTL and testbench

Decode-stage pipeline controller for the MIPS pipeline: it sequences the decode stage (register operands plus sign-extended immediate) by stalling fetch/decode on load-use hazards, flushing IF/ID on taken branches and jumps, and draining the pipeline after a HALT instruction. It sits beside the IF/ID and ID/EX registers and drives their write/flush/bubble controls and the PC write enable. It also reports halt status and a saturating load-use stall count to the debug unit.

---
 rtl/id_stage_controller.sv | 146 ++++++++++++++
 tb/tb_id_stage_controller.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_controller.sv
// Decode-stage pipeline controller: load-use stalls, branch/jump flushes of IF/ID,
// HALT drain sequencing, and a saturating load-use stall counter for the debug unit.
module id_stage_controller #(
  parameter int unsigned           NB_REG       = 5,
  parameter int unsigned           NB_OPCODE    = 6,
  parameter logic [NB_OPCODE-1:0]  HALT_OPCODE  = 6'b111111,
  parameter int unsigned           DRAIN_CYCLES = 4,
  parameter int unsigned           NB_STALL_CNT = 16
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic [NB_OPCODE-1:0]    i_id_opcode,
  input  logic [NB_REG-1:0]       i_id_rs,
  input  logic [NB_REG-1:0]       i_id_rt,
  input  logic                    i_ex_mem_read,
  input  logic [NB_REG-1:0]       i_ex_rt,
  input  logic                    i_branch_taken,
  input  logic                    i_jump,
  output logic                    o_pc_write,
  output logic                    o_if_id_write,
  output logic                    o_if_id_flush,
  output logic                    o_id_ex_bubble,
  output logic                    o_halted,
  output logic [NB_STALL_CNT-1:0] o_stall_count
);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StDrain  = 2'b01,
    StHalted = 2'b10
  } state_e;

  // The drain counter holds remaining bubbles minus one, so zero means "last bubble".
  localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);

  localparam logic [NB_STALL_CNT-1:0] StallOne = {{(NB_STALL_CNT-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [3:0]              drain_cnt_q, drain_cnt_d;
  logic [NB_STALL_CNT-1:0] stall_cnt_q, stall_cnt_d;

  logic load_use_hazard;
  logic halt_in_id;
  logic redirect;
  logic stall_sat;

  // Decode the hazard and control-transfer conditions seen in ID this cycle.
  always_comb begin
    load_use_hazard = i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    halt_in_id      = (i_id_opcode == HALT_OPCODE);
    redirect        = i_branch_taken || i_jump;
    stall_sat       = &stall_cnt_q;
  end

  // Next-state and counter logic; a disabled cycle holds everything.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (i_enable) begin
      unique case (state_q)
        StRun: begin
          if (halt_in_id) begin
            state_d     = StDrain;
            drain_cnt_d = DrainInit;
          end else if (load_use_hazard && !stall_sat) begin
            stall_cnt_d = stall_cnt_q + StallOne;
          end
        end
        StDrain: begin
          if (drain_cnt_q == 4'd0) begin
            state_d = StHalted;
          end else begin
            drain_cnt_d = drain_cnt_q - 4'd1;
          end
        end
        StHalted: begin
          state_d = StHalted;
        end
        default: begin
          state_d = StRun;
        end
      endcase
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q     <= StRun;
      drain_cnt_q <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Pipeline controls respond in the same cycle; reset low forces every output to zero.
  always_comb begin
    o_pc_write     = 1'b0;
    o_if_id_write  = 1'b0;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    o_halted       = 1'b0;
    o_stall_count  = '0;
    if (i_reset) begin
      o_halted      = (state_q == StHalted);
      o_stall_count = stall_cnt_q;
      if (i_enable) begin
        unique case (state_q)
          StRun: begin
            if (halt_in_id) begin
              // HALT moves on to EX while fetch freezes.
              o_pc_write    = 1'b0;
              o_if_id_write = 1'b0;
            end else if (load_use_hazard) begin
              // Hazard wins over a redirect; the branch re-resolves next cycle.
              o_id_ex_bubble = 1'b1;
            end else if (redirect) begin
              o_pc_write    = 1'b1;
              o_if_id_write = 1'b1;
              o_if_id_flush = 1'b1;
            end else begin
              o_pc_write    = 1'b1;
              o_if_id_write = 1'b1;
            end
          end
          StDrain: begin
            o_id_ex_bubble = 1'b1;
          end
          StHalted: begin
            o_id_ex_bubble = 1'b0;
          end
          default: begin
            o_id_ex_bubble = 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_stage_controller.sv
// Self-checking bench for id_stage_controller: directed steps, randomized traffic and
// stall-counter saturation, all compared against a behavioural model each cycle.
module tb_id_stage_controller;

  localparam int unsigned DrainCycles = 4;
  localparam logic [5:0]  HaltOp      = 6'b111111;
  localparam int          StallMax    = 65535;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [5:0]  opcode;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        ex_mem_read, branch_taken, jump;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, halted;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = running, 1 = draining, 2 = halted.
  int mode       = 0;
  int drain_left = 0;
  int stalls     = 0;

  id_stage_controller #(
    .NB_REG      (5),
    .NB_OPCODE   (6),
    .HALT_OPCODE (HaltOp),
    .DRAIN_CYCLES(DrainCycles),
    .NB_STALL_CNT(16)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_enable      (en),
    .i_id_opcode   (opcode),
    .i_id_rs       (id_rs),
    .i_id_rt       (id_rt),
    .i_ex_mem_read (ex_mem_read),
    .i_ex_rt       (ex_rt),
    .i_branch_taken(branch_taken),
    .i_jump        (jump),
    .o_pc_write    (pc_write),
    .o_if_id_write (if_id_write),
    .o_if_id_flush (if_id_flush),
    .o_id_ex_bubble(id_ex_bubble),
    .o_halted      (halted),
    .o_stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_hazard();
    return ex_mem_read && (ex_rt != 0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

  // Compare all outputs against what the model says this cycle's inputs should produce.
  task automatic check_outputs();
    bit e_pc, e_ifw, e_fl, e_bub, e_halt;
    int e_cnt;
    e_pc = 0; e_ifw = 0; e_fl = 0; e_bub = 0; e_halt = 0; e_cnt = 0;
    if (rst_n) begin
      e_halt = (mode == 2);
      e_cnt  = stalls;
      if (en) begin
        if (mode == 0) begin
          if (opcode == HaltOp) begin
            e_pc = 0;
          end else if (model_hazard()) begin
            e_bub = 1;
          end else begin
            e_pc  = 1;
            e_ifw = 1;
            e_fl  = branch_taken || jump;
          end
        end else if (mode == 1) begin
          e_bub = 1;
        end
      end
    end
    chk("pc_write",    32'(pc_write),     32'(e_pc));
    chk("if_id_write", 32'(if_id_write),  32'(e_ifw));
    chk("if_id_flush", 32'(if_id_flush),  32'(e_fl));
    chk("bubble",      32'(id_ex_bubble), 32'(e_bub));
    chk("halted",      32'(halted),       32'(e_halt));
    chk("stall_count", 32'(stall_count),  32'(e_cnt));
  endtask

  // Advance the model across the clock edge using the inputs that were applied.
  task automatic model_update();
    if (!rst_n) begin
      mode = 0; drain_left = 0; stalls = 0;
    end else if (en) begin
      if (mode == 0) begin
        if (opcode == HaltOp) begin
          mode       = 1;
          drain_left = DrainCycles;
        end else if (model_hazard() && stalls < StallMax) begin
          stalls++;
        end
      end else if (mode == 1) begin
        drain_left--;
        if (drain_left == 0) mode = 2;
      end
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    en = 1; opcode = 6'h00; id_rs = 5'd1; id_rt = 5'd2;
    ex_mem_read = 0; ex_rt = 5'd0; branch_taken = 0; jump = 0;
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1;

    // Idle running.
    tick();
    tick();
    chk("idle_pc_write", 32'(pc_write), 32'd1);

    // Load-use hazard with a taken branch: stall wins.
    ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; branch_taken = 1;
    #1;
    chk("hz_bubble", 32'(id_ex_bubble), 32'd1);
    chk("hz_flush",  32'(if_id_flush),  32'd0);
    tick();
    idle_inputs();
    #1;
    chk("hz_count", 32'(stall_count), 32'd1);

    // Destination r0 never hazards.
    ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    tick();
    idle_inputs();

    // Hazard via rt, back to back.
    ex_mem_read = 1; ex_rt = 5'd7; id_rt = 5'd7;
    tick();
    tick();
    idle_inputs();

    // Jump with no hazard flushes.
    jump = 1;
    #1;
    chk("jump_flush", 32'(if_id_flush), 32'd1);
    tick();
    idle_inputs();

    // HALT with enable dropped mid-drain and hazards/branches presented during drain.
    opcode = HaltOp;
    tick();
    opcode = 6'h00;
    ex_mem_read = 1; ex_rt = 5'd3; id_rs = 5'd3; branch_taken = 1;
    tick();
    en = 0;
    tick();
    tick();
    en = 1;
    tick();
    tick();
    tick();
    idle_inputs();
    #1;
    chk("halted_after_drain", 32'(halted), 32'd1);
    tick();
    tick();

    // Reset mid-drain.
    rst_n = 0;
    tick();
    rst_n = 1;
    opcode = HaltOp;
    tick();
    opcode = 6'h00;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    chk("rst_drain_halted", 32'(halted), 32'd0);
    tick();

    // Randomized traffic with occasional resets and enable drops.
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 59) != 0);
      en           = ($urandom_range(0, 5) != 0);
      opcode       = ($urandom_range(0, 39) == 0) ? HaltOp : 6'($urandom_range(0, 62));
      id_rs        = 5'($urandom_range(0, 7));
      id_rt        = 5'($urandom_range(0, 7));
      ex_rt        = 5'($urandom_range(0, 7));
      ex_mem_read  = $urandom_range(0, 1) == 1;
      branch_taken = $urandom_range(0, 3) == 0;
      jump         = $urandom_range(0, 5) == 0;
      tick();
    end

    // Saturation of the stall counter.
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
    ex_mem_read = 1; ex_rt = 5'd9; id_rs = 5'd9;
    for (int i = 0; i < 65540; i++) begin
      tick();
    end
    idle_inputs();
    #1;
    chk("stall_saturated", 32'(stall_count), 32'h0000_FFFF);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
